hilo_write_unit: RTL and testbench

//  Producer side of the HI/LO path: executes MULT/MULTU/DIV/DIVU/MTHI/MTLO in EX and

---
 rtl/hilo_write_unit.sv | 191 +++++++++++++++++++
 tb/tb_hilo_write_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hilo_write_unit.sv
// rtl/hilo_write_unit.sv - HI/LO producer: MTHI/MTLO, 2-cycle multiply, 32-step restoring divide
module hilo_write_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic             stall_req,
    output logic             busy,
    output logic             hilo_write_en,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   opnd_a_q, opnd_b_q;
    logic               sgn_q, q_neg_q, r_neg_q;
    logic [WIDTH-1:0]   hi_res_q, lo_res_q;
    logic [WIDTH-1:0]   hold_hi_q, hold_lo_q;

    logic               is_mul, is_div, accept, div_zero, op_signed;
    logic               a_neg, b_neg, last_step;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] mul_ext_a, mul_ext_b, product;
    logic [WIDTH:0]     partial, diff;
    logic               step_ge;
    logic [WIDTH-1:0]   rem_next, quo_next;

    logic               wr_en;
    logic [WIDTH-1:0]   wr_hi, wr_lo;

    assign is_mul    = op_valid & ((op == OP_MULT) | (op == OP_MULTU));
    assign is_div    = op_valid & ((op == OP_DIV)  | (op == OP_DIVU));
    assign accept    = (state_q == S_IDLE) & (is_mul | is_div) & ~flush;
    assign div_zero  = (operand_b == '0);
    assign op_signed = (op == OP_MULT) | (op == OP_DIV);
    assign a_neg     = op_signed & operand_a[WIDTH-1];
    assign b_neg     = op_signed & operand_b[WIDTH-1];
    assign a_mag     = a_neg ? (-operand_a) : operand_a;
    assign b_mag     = b_neg ? (-operand_b) : operand_b;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // Sign- or zero-extend to 2W so one truncated multiply serves both MULT and MULTU.
    assign mul_ext_a = sgn_q ? {{WIDTH{opnd_a_q[WIDTH-1]}}, opnd_a_q} : {{WIDTH{1'b0}}, opnd_a_q};
    assign mul_ext_b = sgn_q ? {{WIDTH{opnd_b_q[WIDTH-1]}}, opnd_b_q} : {{WIDTH{1'b0}}, opnd_b_q};
    assign product   = mul_ext_a * mul_ext_b;

    // Restoring step: hi_res holds the partial remainder, lo_res shifts dividend out / quotient in.
    assign partial   = {hi_res_q, lo_res_q[WIDTH-1]};
    assign diff      = partial - {1'b0, opnd_b_q};
    assign step_ge   = ~diff[WIDTH];
    assign rem_next  = step_ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign quo_next  = {lo_res_q[WIDTH-2:0], step_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul)        state_d = S_MUL;
                        else if (div_zero) state_d = S_DONE;
                        else               state_d = S_DIV;
                    end
                end
                S_MUL:   state_d = S_DONE;
                S_DIV:   if (last_step) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en = 1'b0;
        wr_hi = hi_res_q;
        wr_lo = lo_res_q;
        if (rst_n && !flush) begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid && op == OP_MTHI) begin
                        wr_en = 1'b1;
                        wr_hi = operand_a;
                        wr_lo = lo_i;
                    end else if (op_valid && op == OP_MTLO) begin
                        wr_en = 1'b1;
                        wr_hi = hi_i;
                        wr_lo = operand_a;
                    end
                end
                S_DONE:  wr_en = 1'b1;
                default: wr_en = 1'b0;
            endcase
        end
    end

    assign stall_req     = rst_n & ~flush & (accept | (state_q == S_MUL) | (state_q == S_DIV));
    assign busy          = rst_n & (state_q != S_IDLE);
    assign hilo_write_en = wr_en;
    assign hi_o          = wr_en ? wr_hi : hold_hi_q;
    assign lo_o          = wr_en ? wr_lo : hold_lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            opnd_a_q <= '0;
            opnd_b_q <= '0;
            sgn_q    <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            hi_res_q <= '0;
            lo_res_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        sgn_q    <= op_signed;
                        opnd_a_q <= operand_a;
                        opnd_b_q <= is_div ? b_mag : operand_b;
                        q_neg_q  <= a_neg ^ b_neg;
                        r_neg_q  <= a_neg;
                        if (is_div) begin
                            // Divide-by-zero skips iteration and reports raw dividend in HI.
                            hi_res_q <= div_zero ? operand_a : '0;
                            lo_res_q <= div_zero ? '1 : a_mag;
                        end
                    end
                end
                S_MUL: begin
                    {hi_res_q, lo_res_q} <= product;
                end
                S_DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        hi_res_q <= r_neg_q ? (-rem_next) : rem_next;
                        lo_res_q <= q_neg_q ? (-quo_next) : quo_next;
                    end else begin
                        hi_res_q <= rem_next;
                        lo_res_q <= quo_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_hi_q <= '0;
            hold_lo_q <= '0;
        end else if (wr_en) begin
            hold_hi_q <= wr_hi;
            hold_lo_q <= wr_lo;
        end
    end

endmodule

// File: tb/tb_hilo_write_unit.sv
// tb/tb_hilo_write_unit.sv - directed vector bench for hilo_write_unit
module tb_hilo_write_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] operand_a, operand_b, hi_i, lo_i;
    logic        stall_req, busy, hilo_write_en;
    logic [31:0] hi_o, lo_o;

    int n_cmp  = 0;
    int n_fail = 0;

    hilo_write_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .op_valid(op_valid), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .hi_i(hi_i), .lo_i(lo_i),
        .stall_req(stall_req), .busy(busy), .hilo_write_en(hilo_write_en),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [31:0] ehi, elo;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run_op(input string nm, input vec_t v);
        int   cycles;
        logic early;
        cycles = 0;
        early  = 1'b0;
        op_valid = 1'b1; op = v.op; operand_a = v.a; operand_b = v.b; hi_i = v.hi; lo_i = v.lo;
        @(negedge clk);
        while (stall_req && cycles < 60) begin
            if (hilo_write_en) early = 1'b1;
            cycles++;
            @(negedge clk);
        end
        chk({nm, "_stall_cycles"}, 64'(cycles), 64'(v.lat));
        chk({nm, "_early_we"}, 64'(early), 64'd0);
        chk({nm, "_we"}, 64'(hilo_write_en), 64'd1);
        chk({nm, "_hi"}, 64'(hi_o), 64'(v.ehi));
        chk({nm, "_lo"}, 64'(lo_o), 64'(v.elo));
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        @(negedge clk);
        chk({nm, "_we_after"}, 64'(hilo_write_en), 64'd0);
        chk({nm, "_busy_after"}, 64'(busy), 64'd0);
        chk({nm, "_hold"}, {hi_o, lo_o}, {v.ehi, v.elo});
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic saw;
        vec_t v;

        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA, 2};
        vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,  32'h00000002, 32'hFFFFFFFA, 2};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{3'd4, 32'd100,      32'd7,        32'h0,  32'h0,  32'd2,        32'd14,       33};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,  32'h0,  32'h0,        32'h80000000, 33};
        vecs[5]  = '{3'd4, 32'd5,        32'd0,        32'h0,  32'h0,  32'd5,        32'hFFFFFFFF, 1};
        vecs[6]  = '{3'd5, 32'h12345678, 32'h0,        32'h55, 32'hAA, 32'h12345678, 32'h000000AA, 0};
        vecs[7]  = '{3'd6, 32'hCAFEBABE, 32'h0,        32'h99, 32'h77, 32'h00000099, 32'hCAFEBABE, 0};
        vecs[8]  = '{3'd1, 32'd7,        32'hFFFFFFFB, 32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFDD, 2};
        vecs[9]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'd1,        32'hFFFFFFFD, 33};
        vecs[10] = '{3'd3, 32'hFFFFFFF9, 32'd0,        32'h0,  32'h0,  32'hFFFFFFF9, 32'hFFFFFFFF, 1};
        vecs[11] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  32'hFFFFFFFE, 32'h00000001, 2};
        vecs[12] = '{3'd4, 32'hFFFFFFFF, 32'd1,        32'h0,  32'h0,  32'h0,        32'hFFFFFFFF, 33};

        // Reset with an MTHI presented: nothing may be written.
        rst_n = 1'b0; flush = 1'b0; op_valid = 1'b1; op = 3'd5;
        operand_a = 32'hDEADBEEF; operand_b = 32'h0; hi_i = 32'h0; lo_i = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {29'd0, stall_req, busy, hilo_write_en, hi_o, lo_o}, 64'd0);
        op_valid = 1'b0; op = 3'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {29'd0, stall_req, busy, hilo_write_en, hi_o, lo_o}, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // Non-HI/LO opcode with op_valid: no write, no stall.
        op_valid = 1'b1; op = 3'd7; operand_a = 32'h1; operand_b = 32'h1;
        @(negedge clk);
        chk("op7_ignored", {62'd0, stall_req, hilo_write_en}, 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;

        // Flush in IDLE with MTHI suppresses the write.
        flush = 1'b1; op_valid = 1'b1; op = 3'd5; operand_a = 32'h11111111;
        @(negedge clk);
        chk("flush_mthi_we", 64'(hilo_write_en), 64'd0);
        chk("flush_mthi_hold", {hi_o, lo_o}, {32'h0, 32'hFFFFFFFF});
        // Flush in IDLE with DIV present: not accepted.
        op = 3'd3; operand_a = 32'd50; operand_b = 32'd5;
        #1;
        chk("flush_accept_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0; op = 3'd0;
        chk("flush_accept_busy", 64'(busy), 64'd0);

        // DIV aborted by flush at T+10.
        op_valid = 1'b1; op = 3'd3; operand_a = 32'd1000; operand_b = 32'd3;
        saw = 1'b0;
        @(negedge clk);
        chk("fl_div_stall_T", 64'(stall_req), 64'd1);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (hilo_write_en) saw = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("fl_div_stall_flush", 64'(stall_req), 64'd0);
        chk("fl_div_we_flush", 64'(hilo_write_en), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; op_valid = 1'b0; op = 3'd0;
        chk("fl_div_busy_T11", 64'(busy), 64'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hilo_write_en || busy) saw = 1'b1;
        end
        chk("fl_div_no_we", 64'(saw), 64'd0);
        @(posedge clk); #1;
        v = '{3'd4, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 33};
        run_op("after_flush_divu", v);

        // Async reset at T+5 of a DIV.
        op_valid = 1'b1; op = 3'd3; operand_a = 32'd12345; operand_b = 32'd11;
        repeat (5) begin @(posedge clk); #1; end
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {29'd0, stall_req, busy, hilo_write_en, hi_o, lo_o}, 64'd0);
        @(posedge clk); #1;
        op_valid = 1'b0; op = 3'd0;
        rst_n = 1'b1;
        saw = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (hilo_write_en || busy || stall_req || hi_o != 0 || lo_o != 0) saw = 1'b1;
            cyc++;
        end
        chk("rst_mid_quiet", 64'(saw), 64'd0);
        @(posedge clk); #1;
        v = '{3'd1, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 2};
        run_op("after_reset_mult", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
